// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg: definitions shared by the instruction-fetch stage.
//   - RESET_PC_DEF / NOP_INSTR_DEF : default values for the if_stage parameters
//   - fetch_state_t                : fetch FSM states {FETCH, HOLD, DROP}
//   - if_id_t                      : IF/ID register bundle {instr, pc_plus4, valid}
//   - IF_ID_W                      : flattened width of if_id_t
//   - if_id_bubble()               : builds the bubble entry for a given NOP word
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

    function automatic if_id_t if_id_bubble(input logic [31:0] nop_word);
        if_id_t b;
        b.instr    = nop_word;
        b.pc_plus4 = 32'h0000_0000;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// ----------------------------------------------------------------------------
// fetch_skid_buf: one-entry buffer that parks an instruction returned by
// instruction memory while decode is stalled.
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties buffer)
//   load                capture data_in (takes precedence over unload)
//   unload              entry consumed by IF/ID, buffer becomes empty
//   clear               discard the entry (redirect kill)
//   data_in [IF_ID_W]   IF/ID bundle to park
//   data    [IF_ID_W]   parked bundle
//   full                an entry is parked
// ----------------------------------------------------------------------------
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [IF_ID_W-1:0] data_in,
    output logic [IF_ID_W-1:0] data,
    output logic               full
);

    logic [IF_ID_W-1:0] data_reg;
    logic               full_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full_reg <= 1'b0;
        end else if (load) begin
            full_reg <= 1'b1;
        end else if (unload) begin
            full_reg <= 1'b0;
        end
    end

    // Payload needs no reset: it is only looked at while full is set.
    always_ff @(posedge clk) begin
        if (load) begin
            data_reg <= data_in;
        end
    end

    assign data = data_reg;
    assign full = full_reg;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, runs the imem req/ready handshake and loads the IF/ID register.
// Optional build macro: DELAY_SLOT_EN -- when defined, the instruction at
// branch PC+4 is kept (delay slot) instead of being killed by a redirect.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   PCBranchD, PCSrcD      redirect target / request from decode
//   StallF, StallD, FlushD hazard-unit controls
//   imem_req, imem_addr    fetch request and word address
//   imem_ready, imem_rdata fetch completion and instruction word
//   InstrD, PCPlus4D, ValidD  IF/ID register
//   PCF                    current fetch PC
// ----------------------------------------------------------------------------
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCBranchD,
    input  logic        PCSrcD,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] PCF
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  drop_addr_reg, drop_addr_next;
    logic         pending_reg, pending_next;
    if_id_t       ifid_reg, ifid_next;

    logic               skid_load, skid_unload, skid_clear, skid_full;
    logic [IF_ID_W-1:0] skid_data;

    logic   done;
    logic   redirect;
    if_id_t fetched;
    if_id_t bubble;
    if_id_t skid_entry;

    // A request stays up once issued (pending_reg) so StallF cannot pull it
    // back; DROP re-presents the pre-redirect address until memory answers.
    assign imem_req  = !rst && ((state_reg == DROP) || pending_reg ||
                                ((state_reg == FETCH) && !StallF));
    assign imem_addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;

    assign done       = imem_req && imem_ready;
    assign redirect   = PCSrcD && !StallD;
    assign bubble     = if_id_bubble(NOP_INSTR);
    assign skid_entry = skid_full ? if_id_t'(skid_data) : bubble;

    always_comb begin
        fetched.instr    = imem_rdata;
        fetched.pc_plus4 = imem_addr + 32'd4;
        fetched.valid    = 1'b1;
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        drop_addr_next = drop_addr_reg;
        pending_next   = pending_reg;
        ifid_next      = ifid_reg;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        skid_clear     = 1'b0;

        case (state_reg)
            FETCH: begin
                if (redirect) begin
                    pc_next      = PCBranchD;
                    pending_next = 1'b0;
`ifdef DELAY_SLOT_EN
                    ifid_next = done ? fetched : bubble;
`else
                    ifid_next = bubble;
`endif
                    // Memory still owes us a word at the old PC: wait it out.
                    if (imem_req && !imem_ready) begin
                        state_next     = DROP;
                        drop_addr_next = pc_reg;
                    end
                end else if (done) begin
                    pc_next      = pc_reg + 32'd4;
                    pending_next = 1'b0;
                    if (StallD) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_next = fetched;
                    end
                end else begin
                    pending_next = imem_req;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_next    = PCBranchD;
                    skid_clear = 1'b1;
                    state_next = FETCH;
`ifdef DELAY_SLOT_EN
                    ifid_next = skid_entry;
`else
                    ifid_next = bubble;
`endif
                end else if (!StallD && !FlushD) begin
                    // A flush without stall keeps the parked word for later.
                    ifid_next   = skid_entry;
                    skid_unload = 1'b1;
                    state_next  = FETCH;
                end
            end

            DROP: begin
                if (redirect) begin
                    pc_next = PCBranchD;
                end
                if (done) begin
                    state_next = FETCH;
`ifdef DELAY_SLOT_EN
                    if (StallD) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_next = fetched;
                    end
`endif
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase

        if (FlushD) begin
            ifid_next = bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            drop_addr_reg <= 32'h0000_0000;
            pending_reg   <= 1'b0;
            ifid_reg      <= bubble;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            drop_addr_reg <= drop_addr_next;
            pending_reg   <= pending_next;
            ifid_reg      <= ifid_next;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .unload  (skid_unload),
        .clear   (skid_clear),
        .data_in (fetched),
        .data    (skid_data),
        .full    (skid_full)
    );

    assign InstrD   = ifid_reg.instr;
    assign PCPlus4D = ifid_reg.pc_plus4;
    assign ValidD   = ifid_reg.valid;
    assign PCF      = pc_reg;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] PCBranchD;
    logic        PCSrcD, StallF, StallD, FlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCPlus4D, PCF;
    logic        ValidD;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .PCBranchD  (PCBranchD),
        .PCSrcD     (PCSrcD),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .PCF        (PCF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_step   = 0;

    // Reference model: an IF/ID entry, the PC, one outstanding memory request
    // (tagged when a redirect has overtaken it) and a queue of parked words.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ent_t;

    ent_t        m_ifid;
    ent_t        m_skid[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_out_red;
    logic [31:0] m_out_addr;

    bit          last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit sf, input bit sd, input bit fd,
                        input bit ps, input logic [31:0] tgt, input bit rdy);
        bit          e_req;
        bit          done;
        bit          redir;
        logic [31:0] e_addr;
        ent_t        d;
        ent_t        bub;
        bub = '{instr: NOP, pc4: 32'h0, valid: 1'b0};

        rst = r; StallF = sf; StallD = sd; FlushD = fd;
        PCSrcD = ps; PCBranchD = tgt; imem_ready = rdy;

        e_addr = m_pc;
        if (r)                     e_req = 1'b0;
        else if (m_skid.size() > 0) e_req = 1'b0;
        else if (m_out) begin e_req = 1'b1; e_addr = m_out_addr; end
        else                       e_req = !sf;
        imem_rdata = (rdy && e_req) ? mem_word(e_addr) : $urandom;

        #2;
        last_req  = imem_req;
        last_addr = imem_addr;
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk("imem_addr", imem_addr, e_addr);

        @(posedge clk);
        done  = e_req && rdy;
        redir = ps && !sd;
        d     = '{instr: mem_word(e_addr), pc4: e_addr + 32'd4, valid: 1'b1};
        if (r) begin
            m_pc = RST_PC; m_ifid = bub; m_out = 0; m_out_red = 0; m_skid.delete();
        end else begin
            if (m_skid.size() > 0) begin
                if (redir) begin
                    m_pc = tgt;
`ifdef DELAY_SLOT_EN
                    m_ifid = m_skid[0];
`else
                    m_ifid = bub;
`endif
                    m_skid.delete();
                end else if (!sd && !fd) begin
                    m_ifid = m_skid.pop_front();
                end
            end else if (done) begin
                if (m_out && m_out_red) begin
`ifdef DELAY_SLOT_EN
                    if (sd) m_skid.push_back(d); else m_ifid = d;
`endif
                    if (redir) m_pc = tgt;
                end else if (redir) begin
                    m_pc = tgt;
`ifdef DELAY_SLOT_EN
                    m_ifid = d;
`else
                    m_ifid = bub;
`endif
                end else begin
                    m_pc = m_pc + 32'd4;
                    if (sd) m_skid.push_back(d); else m_ifid = d;
                end
                m_out = 0; m_out_red = 0;
            end else if (e_req) begin
                if (redir && !m_out_red) begin m_out_red = 1; m_ifid = bub; end
                if (redir) m_pc = tgt;
                m_out = 1; m_out_addr = e_addr;
            end else if (redir) begin
                m_pc = tgt; m_ifid = bub;
            end
            if (fd) m_ifid = bub;
        end

        #1;
        n_step++;
        $display("step %0d rst=%0b sf=%0b sd=%0b fd=%0b br=%0b tgt=%h rdy=%0b | req=%0b addr=%h PCF=%h InstrD=%h PCPlus4D=%h ValidD=%0b",
                 n_step, r, sf, sd, fd, ps, tgt, rdy, last_req, last_addr, PCF, InstrD, PCPlus4D, ValidD);
        chk("PCF", PCF, m_pc);
        chk("InstrD", InstrD, m_ifid.instr);
        chk("PCPlus4D", PCPlus4D, m_ifid.pc4);
        chk("ValidD", {31'b0, ValidD}, {31'b0, m_ifid.valid});
    endtask

    initial begin
        logic [31:0] held_instr;
        rst = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0;
        PCBranchD = 0; imem_ready = 0; imem_rdata = 0;
        m_pc = RST_PC; m_ifid = '{instr: NOP, pc4: 32'h0, valid: 1'b0};
        m_out = 0; m_out_red = 0; m_out_addr = 0;
        @(posedge clk); #1;

        // Reset state
        step(1, 0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 32'h0, 1);
        chk("rst_req", {31'b0, last_req}, 32'h0);
        chk("rst_pcf", PCF, RST_PC);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcp4", PCPlus4D, 32'h0);
        chk("rst_valid", {31'b0, ValidD}, 32'h0);

        // Zero-wait memory: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 32'h0, 1);
            chk("zw_addr", last_addr, 32'(4 * i));
            chk("zw_pcp4", PCPlus4D, 32'(4 * i + 4));
            chk("zw_valid", {31'b0, ValidD}, 32'h1);
        end

        // Slow memory at PC=8
        step(1, 0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        held_instr = InstrD;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 32'h0, 0);
            chk("wait_req", {31'b0, last_req}, 32'h1);
            chk("wait_addr", last_addr, 32'h8);
            chk("wait_instr", InstrD, held_instr);
            chk("wait_pcp4", PCPlus4D, 32'h8);
        end
        step(0, 0, 0, 0, 0, 32'h0, 1);
        chk("wait_done_instr", InstrD, mem_word(32'h8));
        chk("wait_done_pcp4", PCPlus4D, 32'hC);

        // Redirect while the fetch at 0x20 completes
        step(0, 1, 0, 0, 1, 32'h20, 0);
        chk("br_setup_pcf", PCF, 32'h20);
        step(0, 0, 0, 0, 1, 32'h100, 1);
        chk("br_addr", last_addr, 32'h20);
        chk("br_pcf", PCF, 32'h100);
`ifdef DELAY_SLOT_EN
        chk("br_ds_instr", InstrD, mem_word(32'h20));
        chk("br_ds_valid", {31'b0, ValidD}, 32'h1);
`else
        chk("br_valid", {31'b0, ValidD}, 32'h0);
        chk("br_instr", InstrD, NOP);
`endif
        step(0, 0, 0, 0, 0, 32'h0, 1);
        chk("br_next_addr", last_addr, 32'h100);

        // Redirect to 0x200 with fetch at 0x104 pending -> DROP
        step(0, 0, 0, 0, 1, 32'h200, 0);
        chk("drop_addr0", last_addr, 32'h104);
        chk("drop_pcf", PCF, 32'h200);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 32'h0, 0);
            chk("drop_req", {31'b0, last_req}, 32'h1);
            chk("drop_addr", last_addr, 32'h104);
        end
        step(0, 0, 0, 0, 0, 32'h0, 1);
        chk("drop_done_addr", last_addr, 32'h104);
`ifdef DELAY_SLOT_EN
        chk("drop_ds_instr", InstrD, mem_word(32'h104));
`else
        chk("drop_valid", {31'b0, ValidD}, 32'h0);
`endif
        step(0, 0, 0, 0, 0, 32'h0, 1);
        chk("drop_next_addr", last_addr, 32'h200);

        // StallD when the word at 0x40 returns -> HOLD
        step(0, 1, 0, 0, 1, 32'h40, 0);
        step(0, 0, 1, 0, 0, 32'h0, 1);
        chk("hold_addr", last_addr, 32'h40);
        chk("hold_valid", {31'b0, ValidD}, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0, 1);
        chk("hold_req", {31'b0, last_req}, 32'h0);
        chk("hold_instr", InstrD, NOP);
        step(0, 0, 0, 0, 0, 32'h0, 0);
        chk("unhold_instr", InstrD, mem_word(32'h40));
        chk("unhold_pcp4", PCPlus4D, 32'h44);
        chk("unhold_valid", {31'b0, ValidD}, 32'h1);

        // FlushD with StallD, then reset in the middle of DROP
        step(0, 1, 1, 1, 0, 32'h0, 0);
        chk("flush_instr", InstrD, NOP);
        chk("flush_valid", {31'b0, ValidD}, 32'h0);
        step(0, 0, 0, 0, 1, 32'h300, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 0, 0, 32'h0, 1);
        chk("late_rdy_req", {31'b0, last_req}, 32'h0);
        chk("late_rdy_pcf", PCF, RST_PC);
        chk("late_rdy_valid", {31'b0, ValidD}, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(4) == 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(9) == 0),
                 ($urandom_range(7) == 0),
                 ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : {$urandom_range(32'h3FFF), 2'b00},
                 ($urandom_range(9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
